// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM: state encodings,
// decoded-class bit positions and exception codes.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IF  = 3'd0,
      ST_ID  = 3'd1,
      ST_EXE = 3'd2,
      ST_MEM = 3'd3,
      ST_WB  = 3'd4,
      ST_EXC = 3'd5
   } state_e;

   localparam int CLS_MEM = 0;
   localparam int CLS_WB  = 1;
   localparam int CLS_BR  = 2;

   typedef enum logic [1:0] {
      EXC_NONE    = 2'd0,
      EXC_ILLEGAL = 2'd1,
      EXC_IF_TMO  = 2'd2,
      EXC_MEM_TMO = 2'd3
   } exc_code_e;

   function automatic logic is_onehot3(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Handshake wait counter: clears on clr, counts up on inc, and flags expire
// once it has reached TIMEOUT-1. With TIMEOUT=0 the counter is removed and
// expire is held low.
module mc_wait_timer #(
   parameter int TIMEOUT = 16,
   parameter int TMR_W   = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic inc,
   output logic expire
);

   generate
      if (TIMEOUT == 0) begin : g_off
         logic unused_tie;
         assign unused_tie = clk | resetn | clr | inc;
         assign expire     = 1'b0;
      end else begin : g_on
         localparam int W = (TMR_W < 1) ? 1 : TMR_W;
         localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
         logic [W-1:0] cnt;

         // Wait count; holds at the threshold so it can never wrap.
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn)
               cnt <= '0;
            else if (clr)
               cnt <= '0;
            else if (inc && (cnt != LAST))
               cnt <= cnt + 1'b1;
         end

         assign expire = (cnt == LAST);
      end
   endgenerate

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle instruction sequencer: IF -> ID -> EXE -> (MEM) -> (WB), with
// variable-latency fetch/data handshakes, bounded-wait timeout, flush and
// illegal-class detection.
// Optional build macro MC_CTRL_PERF_CNT_EN adds perf_cycles/perf_retired.
//
// state | meaning
// IF    | fetch request outstanding, wait for if_ready
// ID    | decode / register read, validate class
// EXE   | execute; branch-only retires here
// MEM   | data access outstanding, wait for mem_ready
// WB    | register write-back, retire
// EXC   | one-cycle exception pulse, then refetch same PC
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int TMR_W   = $clog2(TIMEOUT + 1),
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [2:0]       inst_class,
   input  logic             is_load,
   input  logic             flush,
   input  logic             if_ready,
   input  logic             mem_ready,
   output logic             if_req,
   output logic             ir_we,
   output logic             id_en,
   output logic             alu_en,
   output logic             mem_req,
   output logic             mem_we,
   output logic             rf_we,
   output logic             pc_we,
   output logic             exc_valid,
   output logic [1:0]       exc_code,
   output logic [2:0]       state_o
`ifdef MC_CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] perf_cycles,
   output logic [CNT_W-1:0] perf_retired
`endif
);

   state_e    state_q;
   state_e    state_nxt;
   exc_code_e exc_code_q;
   exc_code_e exc_code_nxt;
   logic      wb_q;
   logic      pc_we_raw;
   logic      tmr_clr;
   logic      tmr_inc;
   logic      tmr_expire;

   // Re-entering a wait state (or flushing) restarts the wait count.
   assign tmr_clr = flush || (state_nxt != state_q);
   assign tmr_inc = ((state_q == ST_IF)  && !if_ready) ||
                    ((state_q == ST_MEM) && !mem_ready);

   mc_wait_timer #(
      .TIMEOUT (TIMEOUT),
      .TMR_W   (TMR_W)
   ) u_wait_timer (
      .clk    (clk),
      .resetn (resetn),
      .clr    (tmr_clr),
      .inc    (tmr_inc),
      .expire (tmr_expire)
   );

   // Next-state and retire decode; ready wins over timeout, flush wins over all.
   always_comb begin
      state_nxt    = state_q;
      exc_code_nxt = exc_code_q;
      pc_we_raw    = 1'b0;
      case (state_q)
         ST_IF: begin
            if (if_ready) begin
               state_nxt = ST_ID;
            end else if (tmr_expire) begin
               state_nxt    = ST_EXC;
               exc_code_nxt = EXC_IF_TMO;
            end
         end
         ST_ID: begin
            if (!is_onehot3(inst_class)) begin
               state_nxt    = ST_EXC;
               exc_code_nxt = EXC_ILLEGAL;
            end else begin
               state_nxt = ST_EXE;
            end
         end
         ST_EXE: begin
            if (inst_class[CLS_MEM]) begin
               state_nxt = ST_MEM;
            end else if (inst_class[CLS_WB]) begin
               state_nxt = ST_WB;
            end else begin
               state_nxt = ST_IF;
               pc_we_raw = inst_class[CLS_BR];
            end
         end
         ST_MEM: begin
            if (mem_ready) begin
               if (is_load) begin
                  state_nxt = ST_WB;
               end else begin
                  state_nxt = ST_IF;
                  pc_we_raw = 1'b1;
               end
            end else if (tmr_expire) begin
               state_nxt    = ST_EXC;
               exc_code_nxt = EXC_MEM_TMO;
            end
         end
         ST_WB: begin
            state_nxt = ST_IF;
            pc_we_raw = 1'b1;
         end
         ST_EXC: begin
            state_nxt = ST_IF;
         end
         default: begin
            state_nxt = ST_IF;
         end
      endcase
      if (flush) begin
         state_nxt    = ST_IF;
         exc_code_nxt = exc_code_q;
      end
   end

   // State register with Moore outputs registered from the next state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IF;
         exc_code_q <= EXC_NONE;
         if_req     <= 1'b1;
         id_en      <= 1'b0;
         alu_en     <= 1'b0;
         mem_req    <= 1'b0;
         wb_q       <= 1'b0;
         exc_valid  <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         exc_code_q <= exc_code_nxt;
         if_req     <= (state_nxt == ST_IF);
         id_en      <= (state_nxt == ST_ID);
         alu_en     <= (state_nxt == ST_EXE);
         mem_req    <= (state_nxt == ST_MEM);
         wb_q       <= (state_nxt == ST_WB);
         exc_valid  <= (state_nxt == ST_EXC);
      end
   end

   // Commit strobes are suppressed in a flush cycle.
   assign ir_we    = if_req && if_ready && !flush;
   assign pc_we    = pc_we_raw && !flush;
   assign rf_we    = wb_q && !flush;
   assign mem_we   = mem_req && !is_load;
   assign exc_code = exc_code_q;
   assign state_o  = state_q;

`ifdef MC_CTRL_PERF_CNT_EN
   // Free-running cycle count and retired-instruction count, both wrapping.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         perf_cycles  <= '0;
         perf_retired <= '0;
      end else begin
         perf_cycles <= perf_cycles + 1'b1;
         if (pc_we)
            perf_retired <= perf_retired + 1'b1;
      end
   end
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm (TIMEOUT=4).
module tb_mc_ctrl_fsm;

   logic        clk;
   logic        resetn;
   logic [2:0]  inst_class;
   logic        is_load;
   logic        flush;
   logic        if_ready;
   logic        mem_ready;
   logic        if_req;
   logic        ir_we;
   logic        id_en;
   logic        alu_en;
   logic        mem_req;
   logic        mem_we;
   logic        rf_we;
   logic        pc_we;
   logic        exc_valid;
   logic [1:0]  exc_code;
   logic [2:0]  state_o;
`ifdef MC_CTRL_PERF_CNT_EN
   logic [31:0] perf_cycles;
   logic [31:0] perf_retired;
`endif

   int checks = 0;
   int errors = 0;

   mc_ctrl_fsm #(.TIMEOUT(4), .CNT_W(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .inst_class (inst_class),
      .is_load    (is_load),
      .flush      (flush),
      .if_ready   (if_ready),
      .mem_ready  (mem_ready),
      .if_req     (if_req),
      .ir_we      (ir_we),
      .id_en      (id_en),
      .alu_en     (alu_en),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .rf_we      (rf_we),
      .pc_we      (pc_we),
      .exc_valid  (exc_valid),
      .exc_code   (exc_code),
      .state_o    (state_o)
`ifdef MC_CTRL_PERF_CNT_EN
      ,
      .perf_cycles  (perf_cycles),
      .perf_retired (perf_retired)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cyc(input string tag, input int st, input logic pc, input logic rf);
      chk({tag, " state"}, 32'(state_o), 32'(st));
      chk({tag, " pc_we"}, 32'(pc_we), 32'(pc));
      chk({tag, " rf_we"}, 32'(rf_we), 32'(rf));
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   int st_alu_ld [9] = '{0, 1, 2, 4, 0, 1, 2, 3, 4};
   int st_store  [7] = '{0, 1, 2, 3, 3, 3, 3};
   int st_if_tmo [5] = '{0, 0, 0, 0, 5};

   initial begin
      resetn     = 1'b1;
      inst_class = 3'b000;
      is_load    = 1'b0;
      flush      = 1'b0;
      if_ready   = 1'b0;
      mem_ready  = 1'b0;
      #1 resetn  = 1'b0;
      #2;
      // reset values
      chk("rst state", 32'(state_o), 32'd0);
      chk("rst if_req", 32'(if_req), 32'd1);
      chk("rst ir_we", 32'(ir_we), 32'd0);
      chk("rst id_en", 32'(id_en), 32'd0);
      chk("rst alu_en", 32'(alu_en), 32'd0);
      chk("rst mem_req", 32'(mem_req), 32'd0);
      chk("rst mem_we", 32'(mem_we), 32'd0);
      chk("rst rf_we", 32'(rf_we), 32'd0);
      chk("rst pc_we", 32'(pc_we), 32'd0);
      chk("rst exc_valid", 32'(exc_valid), 32'd0);
      chk("rst exc_code", 32'(exc_code), 32'd0);
`ifdef MC_CTRL_PERF_CNT_EN
      chk("rst perf_cycles", perf_cycles, 32'd0);
      chk("rst perf_retired", perf_retired, 32'd0);
`endif
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;

      // zero-wait ALU (retire cycle 4) then load (retire cycle 9)
      for (int c = 1; c <= 9; c++) begin
         if_ready   = 1'b1;
         mem_ready  = 1'b1;
         inst_class = (c < 5) ? 3'b010 : 3'b001;
         is_load    = 1'b1;
         #1;
         chk_cyc($sformatf("alu_ld c%0d", c), st_alu_ld[c-1], (c == 4) || (c == 9), (c == 4) || (c == 9));
         chk($sformatf("alu_ld c%0d ir_we", c), 32'(ir_we), 32'((c == 1) || (c == 5)));
         next_cyc();
      end

      // store with three wait cycles; ready arrives at the timeout threshold
      for (int c = 1; c <= 7; c++) begin
         if_ready   = 1'b1;
         inst_class = 3'b001;
         is_load    = 1'b0;
         mem_ready  = (c == 7);
         #1;
         chk_cyc($sformatf("store c%0d", c), st_store[c-1], c == 7, 1'b0);
         chk($sformatf("store c%0d mem_we", c), 32'(mem_we), 32'((c >= 4) && (c <= 7)));
         next_cyc();
      end

      // fetch never returns: EXC in cycle 5 with code 2
      for (int c = 1; c <= 5; c++) begin
         if_ready = 1'b0;
         #1;
         chk_cyc($sformatf("if_tmo c%0d", c), st_if_tmo[c-1], 1'b0, 1'b0);
         chk($sformatf("if_tmo c%0d exc_valid", c), 32'(exc_valid), 32'(c == 5));
         next_cyc();
      end
      chk("if_tmo exc_code", 32'(exc_code), 32'd2);

      // illegal class 011: code held at 2 until the new exception
      inst_class = 3'b011;
      if_ready   = 1'b1;
      #1;
      chk_cyc("ill011 c1", 0, 1'b0, 1'b0);
      chk("ill011 c1 exc_valid", 32'(exc_valid), 32'd0);
      chk("ill011 c1 exc_code held", 32'(exc_code), 32'd2);
      next_cyc();
      chk_cyc("ill011 c2", 1, 1'b0, 1'b0);
      next_cyc();
      chk_cyc("ill011 c3", 5, 1'b0, 1'b0);
      chk("ill011 exc_valid", 32'(exc_valid), 32'd1);
      chk("ill011 exc_code", 32'(exc_code), 32'd1);
      next_cyc();

      // illegal class 000
      inst_class = 3'b000;
      #1;
      chk_cyc("ill000 c1", 0, 1'b0, 1'b0);
      next_cyc();
      chk_cyc("ill000 c2", 1, 1'b0, 1'b0);
      next_cyc();
      chk_cyc("ill000 c3", 5, 1'b0, 1'b0);
      chk("ill000 exc_code", 32'(exc_code), 32'd1);
      next_cyc();

      // flush during WB
      inst_class = 3'b010;
      for (int c = 1; c <= 3; c++) next_cyc();
      flush = 1'b1;
      #1;
      chk_cyc("flush_wb", 4, 1'b0, 1'b0);
      next_cyc();
      flush = 1'b0;
      #1;
      chk_cyc("flush_wb next", 0, 1'b0, 1'b0);

      // flush together with mem_ready on a load
      inst_class = 3'b001;
      is_load    = 1'b1;
      mem_ready  = 1'b1;
      for (int c = 1; c <= 3; c++) next_cyc();
      flush = 1'b1;
      #1;
      chk_cyc("flush_mem", 3, 1'b0, 1'b0);
      next_cyc();
      flush = 1'b0;
      #1;
      chk_cyc("flush_mem next", 0, 1'b0, 1'b0);

      // asynchronous reset while a store waits in MEM
      is_load   = 1'b0;
      mem_ready = 1'b0;
      for (int c = 1; c <= 3; c++) next_cyc();
      #1;
      chk("pre_rst mem_req", 32'(mem_req), 32'd1);
      chk("pre_rst mem_we", 32'(mem_we), 32'd1);
      resetn = 1'b0;
      #1;
      chk("mid_rst state", 32'(state_o), 32'd0);
      chk("mid_rst if_req", 32'(if_req), 32'd1);
      chk("mid_rst mem_req", 32'(mem_req), 32'd0);
      chk("mid_rst mem_we", 32'(mem_we), 32'd0);
      chk("mid_rst exc_code", 32'(exc_code), 32'd0);
`ifdef MC_CTRL_PERF_CNT_EN
      chk("mid_rst perf_cycles", perf_cycles, 32'd0);
      chk("mid_rst perf_retired", perf_retired, 32'd0);
`endif
      @(posedge clk);
      #1 resetn = 1'b1;

      // normal branch after release: retire in cycle 3
      inst_class = 3'b100;
      if_ready   = 1'b1;
      #1;
      chk_cyc("br c1", 0, 1'b0, 1'b0);
      chk("br c1 ir_we", 32'(ir_we), 32'd1);
      next_cyc();
      chk_cyc("br c2", 1, 1'b0, 1'b0);
      next_cyc();
      chk_cyc("br c3", 2, 1'b1, 1'b0);
      next_cyc();
      chk_cyc("br c4", 0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
